// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Types and constants shared by the UART receive and transmit
//               paths.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int UART_DATA_BITS            = 8;
   localparam int UART_DEFAULT_CLKS_PER_BIT = 16;

   // Receiver frame-tracking states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } uart_rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync
// Description : Two-flop synchroniser for a single asynchronous input, with a
//               selectable reset value so an idle-high line reads idle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops; the first may go metastable, the second resolves it
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta <= RESET_VALUE;
         q    <= RESET_VALUE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule : uart_sync
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receiver, LSB first, fixed clocks-per-bit divider.
//               Start bit validated at mid-bit; received bytes are offered
//               through a one-entry valid/ready holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       io_rxd,
   output logic [7:0] io_data,
   output logic       io_valid,
   input  logic       io_ready,
   output logic       io_frame_err,
   output logic       io_overrun
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int HALF  = CLKS_PER_BIT / 2;

   // Counter reload values: the counter samples when it reaches zero, one
   // cycle after the last decrement, so a wait of W cycles reloads with W-1.
   // The start wait loads one less again because the IDLE detection cycle
   // already consumes one of the H cycles.
   localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 2);

   logic                      rxd_s;
   uart_rx_state_t            state, state_d;
   logic [CNT_W-1:0]          cnt, cnt_d;
   logic [2:0]                idx, idx_d;
   logic [UART_DATA_BITS-1:0] shift, shift_d;
   logic                      stop_ok;
   logic                      stop_bad;

   logic [7:0]                data;
   logic                      valid;
   logic                      frame_err;
   logic                      overrun;

   uart_sync #(
      .RESET_VALUE (1'b1)
   ) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (io_rxd),
      .q     (rxd_s)
   );

   // Frame state, bit counter, bit index and shift register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         idx   <= idx_d;
         shift <= shift_d;
      end
   end

   // Next-state logic: track the frame and flag the stop-bit outcome
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      idx_d    = idx;
      shift_d  = shift;
      stop_ok  = 1'b0;
      stop_bad = 1'b0;
      case (state)
         IDLE: begin
            if (!rxd_s) begin
               state_d = START;
               cnt_d   = HALF_LOAD;
            end
         end
         START: begin
            if (cnt == '0) begin
               if (!rxd_s) begin
                  state_d = DATA;
                  idx_d   = 3'd0;
                  cnt_d   = BIT_LOAD;
               end else begin
                  // Line went back high before mid-bit: a glitch, not a start
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         DATA: begin
            if (cnt == '0) begin
               shift_d[idx] = rxd_s;
               cnt_d        = BIT_LOAD;
               if (idx == 3'd7) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx + 3'd1;
               end
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         STOP: begin
            if (cnt == '0) begin
               if (rxd_s) begin
                  stop_ok = 1'b1;
                  state_d = IDLE;
               end else begin
                  stop_bad = 1'b1;
                  state_d  = WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         WAIT_HIGH: begin
            // A held-low (break) line must not be mistaken for a new start bit
            if (rxd_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Holding register with valid/ready handshake plus error pulses
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         overrun   <= 1'b0;
         if (valid && io_ready) begin
            valid <= 1'b0;
         end
         if (stop_ok) begin
            if (!valid || io_ready) begin
               data  <= shift;
               valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

   assign io_data      = data;
   assign io_valid     = valid;
   assign io_frame_err = frame_err;
   assign io_overrun   = overrun;

endmodule : uart_receiver
`default_nettype wire
